// File: rtl/dut_grant_burst.sv
// Grant-burst generator: a rising edge of req starts a burst of num_grants grant cycles,
// with last marking the final grant. Optional DUT_ABORT_EN lets req falling mid-burst abort it.
module dut_grant_burst (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [2:0] num_grants,
  output logic       gnt,
  output logic       last
);

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StDone
  } state_e;

  state_e     state_q;
  logic       req_q;
  logic [2:0] remain_q;
  logic       rise;
  logic       abort;

  assign rise = req & ~req_q;

`ifdef DUT_ABORT_EN
  assign abort = ~req;
`else
  assign abort = 1'b0;
`endif

  // remain_q counts grants still owed, including the one currently on gnt.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      req_q    <= 1'b0;
      remain_q <= 3'd0;
      gnt      <= 1'b0;
      last     <= 1'b0;
    end else begin
      req_q <= req;
      gnt   <= 1'b0;
      last  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (rise) begin
            remain_q <= num_grants;
            if (num_grants != 3'd0) begin
              state_q <= StGrant;
              gnt     <= 1'b1;
              last    <= (num_grants == 3'd1);
            end else begin
              // Zero-length burst: pulse last alone.
              state_q <= StDone;
              last    <= 1'b1;
            end
          end
        end
        StGrant: begin
          if (abort) begin
            state_q  <= StIdle;
            remain_q <= 3'd0;
          end else if (remain_q == 3'd1) begin
            state_q  <= StDone;
            remain_q <= 3'd0;
          end else begin
            remain_q <= remain_q - 3'd1;
            gnt      <= 1'b1;
            last     <= (remain_q == 3'd2);
          end
        end
        StDone: begin
          if (!req) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dut_grant_burst.sv
// Self-checking bench for dut_grant_burst: a table of per-cycle vectors plus hand-written
// sequences; expected outputs go through a scoreboard queue and are checked after each edge.
module tb_dut_grant_burst;

  logic       clk;
  logic       reset;
  logic       req;
  logic [2:0] num_grants;
  logic       gnt;
  logic       last;

  dut_grant_burst u_dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .num_grants(num_grants),
    .gnt       (gnt),
    .last      (last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       rst_n;
    bit       req;
    bit [2:0] ng;
    bit       gnt;
    bit       last;
  } vec_t;

  typedef struct {
    int id;
    bit gnt;
    bit last;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   step_id  = 0;

  function automatic void add(bit rst_n, bit r, bit [2:0] ng, bit g, bit l);
    vec_t v;
    v.rst_n = rst_n;
    v.req   = r;
    v.ng    = ng;
    v.gnt   = g;
    v.last  = l;
    vecs.push_back(v);
  endfunction

  // Drive one cycle of inputs, expect (g, l) on the outputs after the next rising edge.
  task automatic step(input bit rst_n, input bit r, input bit [2:0] ng, input bit g, input bit l);
    exp_t e;
    exp_t got;
    @(negedge clk);
    reset      = rst_n;
    req        = r;
    num_grants = ng;
    e.id   = step_id;
    e.gnt  = g;
    e.last = l;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    n_checks++;
    if (sbq.size() == 0) begin
      n_errors++;
      $display("FAIL step %0d scoreboard: got empty queue, want one entry", step_id);
    end else begin
      got = sbq.pop_front();
      if (gnt !== got.gnt) begin
        n_errors++;
        $display("FAIL step %0d gnt: got %b want %b", got.id, gnt, got.gnt);
      end
      n_checks++;
      if (last !== got.last) begin
        n_errors++;
        $display("FAIL step %0d last: got %b want %b", got.id, last, got.last);
      end
    end
    step_id++;
  endtask

  initial begin
    reset      = 1'b0;
    req        = 1'b0;
    num_grants = 3'd0;

    // Reset state
    add(0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0);
    add(1, 0, 2, 0, 0);
    // N=2, req held through last, then back-to-back N=3
    add(1, 1, 2, 1, 0);
    add(1, 1, 2, 1, 1);
    add(1, 1, 2, 0, 0);
    add(1, 0, 2, 0, 0);
    add(1, 1, 3, 1, 0);
    add(1, 1, 3, 1, 0);
    add(1, 1, 3, 1, 1);
    add(1, 1, 3, 0, 0);
    add(1, 0, 3, 0, 0);
    // N=1
    add(1, 1, 1, 1, 1);
    add(1, 1, 1, 0, 0);
    add(1, 0, 1, 0, 0);
    // N=0: last alone, no grant
    add(1, 1, 0, 0, 1);
    add(1, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0);
    // Reset one cycle into a 4-grant burst, release with req high restarts it
    add(1, 1, 4, 1, 0);
    add(0, 1, 4, 0, 0);
    add(1, 1, 4, 1, 0);
    add(1, 1, 4, 1, 0);
    add(1, 1, 4, 1, 0);
    add(1, 1, 4, 1, 1);
    add(1, 1, 4, 0, 0);
    add(1, 0, 4, 0, 0);
    // N=5 with req dropped two cycles in
    add(1, 1, 5, 1, 0);
    add(1, 1, 5, 1, 0);
`ifdef DUT_ABORT_EN
    add(1, 0, 5, 0, 0);
    add(1, 0, 5, 0, 0);
    add(1, 0, 5, 0, 0);
    add(1, 0, 5, 0, 0);
    add(1, 0, 5, 0, 0);
`else
    add(1, 0, 5, 1, 0);
    add(1, 0, 5, 1, 0);
    add(1, 0, 5, 1, 1);
    add(1, 0, 5, 0, 0);
    add(1, 0, 5, 0, 0);
`endif

    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].req, vecs[i].ng, vecs[i].gnt, vecs[i].last);
    end

    // N=7; num_grants changed to 1 after capture must not shorten the burst
    step(1, 1, 7, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 1, 1, 0);
    step(1, 1, 1, 1, 1);
    // req held high 10 cycles past last: no second burst
    for (int i = 0; i < 10; i++) step(1, 1, 1, 0, 0);
    // One low cycle then high again: new burst of the current num_grants
    step(1, 0, 1, 0, 0);
    step(1, 1, 1, 1, 1);
    step(1, 1, 1, 0, 0);
    step(1, 0, 1, 0, 0);

    // Reset while DONE is held by req; release with req high counts as a fresh rise
    step(1, 1, 2, 1, 0);
    step(1, 1, 2, 1, 1);
    step(1, 1, 2, 0, 0);
    step(0, 1, 2, 0, 0);
    step(1, 1, 2, 1, 0);
    step(1, 1, 2, 1, 1);
    step(1, 1, 2, 0, 0);
    step(1, 0, 2, 0, 0);

    n_checks++;
    if (sbq.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard drain: got %0d entries left, want 0", sbq.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
